id_pipe: RTL and testbench
==========================

# id_pipe

Registered, parametrised MIPS instruction-decode stage: decodes one instruction per cycle from IF/ID, reads the Regfile, resolves operands with EX/MEM forwarding, detects load-use hazards, and holds the result in an ID/EX output register under a valid/ready handshake. It sits between the IF/ID register and EX. It supersedes the purely combinational ORI-only decoder with a full logic/shift/arithmetic/load subset, stall/flush control and a stall performance counter.

## Interface
- DATA_W, 32, data and immediate-extension width
- REG_AW, 5, register address width
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = operands from Regfile only, and every RAW match on EX or MEM stalls
- STALL_CNT_W, 16, width of saturating stall counter
---
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high (`RstEnable = 1'b1)
- in_valid / in_ready  in / out  1  IF/ID handshake
- pc_i  in  `InstAddrBus  instruction address
- inst_i  in  `InstBus  instruction word
- reg1_read_o, reg2_read_o  out  1  Regfile read enables (combinational)
- reg1_addr_o, reg2_addr_o  out  REG_AW  inst[25:21], inst[20:16] (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W  Regfile read data, same cycle
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_AW/DATA_W/1  EX-stage result
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage result
- flush_i  in  1  discard current and registered instruction
- out_valid / out_ready  out / in  1  ID/EX handshake
- aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o  out  registered decode outputs
- stall_cnt_o  out  STALL_CNT_W  load-use stall cycles, saturating

## Operation
- Decoded set: ORI, ANDI, XORI, LUI, ADDIU, SLTI, LW; SPECIAL (op 000000) AND, OR, XOR, NOR, ADDU, SUBU, SLT, SLL, SRL, SRA.
- Immediates: logic ops (ORI/ANDI/XORI) zero-extend inst[15:0]. ADDIU/SLTI/LW sign-extend it. LUI uses {inst[15:0], 16'h0}. Shifts place the shamt inst[10:6], zero-extended, in reg1_o, with rt in reg2_o.
- Destination: I-type → rt, R-type → rd.
- Unread operand ports carry the immediate.
- Unknown opcode/funct: aluop=`EXE_NOP_OP, wreg_o=0, inst_invalid_o=1, out_valid still asserted.
- Operand priority per port, only when its read enable is set:
  - register 0 → 0
  - EX match (ex_wreg_i && ex_wd_i==addr, not load) → ex_wdata_i
  - MEM match → mem_wdata_i
  - otherwise Regfile data
- Load-use stall: ex_is_load_i && ex_wreg_i && ex_wd_i==addr≠0 on an enabled port.
  - in_ready=0; a bubble (out_valid=0) is loaded when the output register is free.
  - stall_cnt_o increments by one per stalled cycle and saturates at all-ones.
- in_ready = !stall && (!out_valid || out_ready).
- Output register loads when in_valid && in_ready.

## Timing
- Latency: 1 cycle, inst_i to out_valid. Throughput: 1/cycle without backpressure.
- out_valid && !out_ready: all outputs hold stable; upstream sees in_ready=0.
- flush_i:
  - out_valid clears next cycle.
  - The input that cycle is accepted and dropped (in_ready=1).
  - flush_i overrides both stall and backpressure.
- Async reset:
  - out_valid=0, aluop_o=`EXE_NOP_OP, alusel_o=`EXE_RES_NOP, reg1_o/reg2_o/pc_o=0, wd_o=`NOPRegAddr, wreg_o=0, inst_invalid_o=0, stall_cnt_o=0.
  - Combinational read enables are 0 while rst=1.
  - Reset mid-stall or mid-backpressure discards the held instruction.
- Stall and flush in the same cycle: flush wins; stall_cnt_o does not increment.

## Structure
- Shared package/defines: opcode and funct constants, `EXE_*_OP aluop codes, `EXE_RES_* alusel codes, `RstEnable, `ZeroWord, `NOPRegAddr, bus widths.
- One sub-module, id_decode: pure combinational instruction → {aluop, alusel, read enables, imm, wd, wreg, invalid}.
- Forwarding, hazard detection, handshake, output register and counter stay in id_pipe.

## Test plan
- ori $1,$0,0x1100 (0x34011100) with out_ready=1 → next cycle: out_valid=1, aluop OR, alusel LOGIC, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1.
- or $3,$1,$2 (0x00221825), EX writing r1=0xAAAA0000, MEM writing r2=0x00005555 → reg1_o=0xAAAA0000, reg2_o=0x00005555, wd_o=3.
- EX is lw r4; decode addu $5,$4,$4 (0x00842821):
  - in_ready=0 for one cycle, bubble emitted, stall_cnt_o 0→1.
  - Next cycle (load now in MEM) the instruction is accepted with the MEM value.
- out_ready=0 for 3 cycles with out_valid=1 → all outputs constant, in_ready=0; release → next instruction loads.
- flush_i pulsed with valid input and a registered valid output → out_valid=0 next cycle, neither instruction appears.
- Opcode 0x3F → out_valid=1, inst_invalid_o=1, wreg_o=0. Assert rst mid-backpressure → outputs return to reset values immediately.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared constants for the id_pipe decode stage: opcodes, function codes,
// ALU operation / result-select encodings and bus widths.
package id_pipe_pkg;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam int          INST_W       = 32;
    localparam int          INST_ADDR_W  = 32;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [7:0] {
        EXE_NOP_OP   = 8'h00,
        EXE_SRL_OP   = 8'h02,
        EXE_SRA_OP   = 8'h03,
        EXE_ADDU_OP  = 8'h21,
        EXE_SUBU_OP  = 8'h23,
        EXE_AND_OP   = 8'h24,
        EXE_OR_OP    = 8'h25,
        EXE_XOR_OP   = 8'h26,
        EXE_NOR_OP   = 8'h27,
        EXE_SLT_OP   = 8'h2A,
        EXE_ADDIU_OP = 8'h56,
        EXE_SLL_OP   = 8'h7C,
        EXE_LW_OP    = 8'hE3
    } aluop_t;

    typedef enum logic [2:0] {
        EXE_RES_NOP        = 3'b000,
        EXE_RES_LOGIC      = 3'b001,
        EXE_RES_SHIFT      = 3'b010,
        EXE_RES_ARITH      = 3'b100,
        EXE_RES_LOAD_STORE = 3'b111
    } alusel_t;

endpackage

// File: rtl/id_pipe_if.sv
// IF/ID input handshake and ID/EX registered output bundle of the decode stage.
interface id_pipe_if
    import id_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INST_ADDR_W-1:0] pc_i;
    logic [INST_W-1:0]      inst_i;

    logic                   out_valid;
    logic                   out_ready;
    aluop_t                 aluop_o;
    alusel_t                alusel_o;
    logic [DATA_W-1:0]      reg1_o;
    logic [DATA_W-1:0]      reg2_o;
    logic [REG_AW-1:0]      wd_o;
    logic                   wreg_o;
    logic [INST_ADDR_W-1:0] pc_o;
    logic                   inst_invalid_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  in_valid, pc_i, inst_i, out_ready,
        output in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, inst_invalid_o, stall_cnt_o
    );

    modport master (
        output in_valid, pc_i, inst_i, out_ready,
        input  in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
               wd_o, wreg_o, pc_o, inst_invalid_o, stall_cnt_o
    );
endinterface

// File: rtl/id_pipe_decode.sv
// Pure combinational instruction decoder: opcode/funct to ALU controls,
// register read enables/addresses, extended immediate and destination.
module id_decode
    import id_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [INST_W-1:0] inst_i,
    output aluop_t            aluop_o,
    output alusel_t           alusel_o,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              invalid_o
);
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_lui;
    logic [DATA_W-1:0] imm_shamt;

    assign op          = inst_i[31:26];
    assign funct       = inst_i[5:0];
    assign reg1_addr_o = REG_AW'(inst_i[25:21]);
    assign reg2_addr_o = REG_AW'(inst_i[20:16]);
    assign imm_zext    = {{(DATA_W-16){1'b0}}, inst_i[15:0]};
    assign imm_sext    = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
    assign imm_lui     = {inst_i[15:0], {(DATA_W-16){1'b0}}};
    assign imm_shamt   = DATA_W'(inst_i[10:6]);

    always_comb begin
        aluop_o     = EXE_NOP_OP;
        alusel_o    = EXE_RES_NOP;
        reg1_read_o = 1'b0;
        reg2_read_o = 1'b0;
        imm_o       = '0;
        wd_o        = REG_AW'(NOP_REG_ADDR);
        wreg_o      = 1'b0;
        invalid_o   = 1'b1;
        case (op)
            OP_SPECIAL: begin
                wd_o        = REG_AW'(inst_i[15:11]);
                wreg_o      = 1'b1;
                invalid_o   = 1'b0;
                reg1_read_o = 1'b1;
                reg2_read_o = 1'b1;
                case (funct)
                    FN_AND:  begin aluop_o = EXE_AND_OP;  alusel_o = EXE_RES_LOGIC; end
                    FN_OR:   begin aluop_o = EXE_OR_OP;   alusel_o = EXE_RES_LOGIC; end
                    FN_XOR:  begin aluop_o = EXE_XOR_OP;  alusel_o = EXE_RES_LOGIC; end
                    FN_NOR:  begin aluop_o = EXE_NOR_OP;  alusel_o = EXE_RES_LOGIC; end
                    FN_ADDU: begin aluop_o = EXE_ADDU_OP; alusel_o = EXE_RES_ARITH; end
                    FN_SUBU: begin aluop_o = EXE_SUBU_OP; alusel_o = EXE_RES_ARITH; end
                    FN_SLT:  begin aluop_o = EXE_SLT_OP;  alusel_o = EXE_RES_ARITH; end
                    // shifts take the shamt on port 1 instead of rs
                    FN_SLL:  begin aluop_o = EXE_SLL_OP; alusel_o = EXE_RES_SHIFT; reg1_read_o = 1'b0; imm_o = imm_shamt; end
                    FN_SRL:  begin aluop_o = EXE_SRL_OP; alusel_o = EXE_RES_SHIFT; reg1_read_o = 1'b0; imm_o = imm_shamt; end
                    FN_SRA:  begin aluop_o = EXE_SRA_OP; alusel_o = EXE_RES_SHIFT; reg1_read_o = 1'b0; imm_o = imm_shamt; end
                    default: begin
                        wd_o        = REG_AW'(NOP_REG_ADDR);
                        wreg_o      = 1'b0;
                        invalid_o   = 1'b1;
                        reg1_read_o = 1'b0;
                        reg2_read_o = 1'b0;
                    end
                endcase
            end
            OP_ORI:   begin aluop_o = EXE_OR_OP;    alusel_o = EXE_RES_LOGIC;      imm_o = imm_zext; reg1_read_o = 1'b1; end
            OP_ANDI:  begin aluop_o = EXE_AND_OP;   alusel_o = EXE_RES_LOGIC;      imm_o = imm_zext; reg1_read_o = 1'b1; end
            OP_XORI:  begin aluop_o = EXE_XOR_OP;   alusel_o = EXE_RES_LOGIC;      imm_o = imm_zext; reg1_read_o = 1'b1; end
            OP_LUI:   begin aluop_o = EXE_OR_OP;    alusel_o = EXE_RES_LOGIC;      imm_o = imm_lui;  end
            OP_ADDIU: begin aluop_o = EXE_ADDIU_OP; alusel_o = EXE_RES_ARITH;      imm_o = imm_sext; reg1_read_o = 1'b1; end
            OP_SLTI:  begin aluop_o = EXE_SLT_OP;   alusel_o = EXE_RES_ARITH;      imm_o = imm_sext; reg1_read_o = 1'b1; end
            OP_LW:    begin aluop_o = EXE_LW_OP;    alusel_o = EXE_RES_LOAD_STORE; imm_o = imm_sext; reg1_read_o = 1'b1; end
            default:  ;
        endcase
        if (op != OP_SPECIAL && !invalid_o) begin
            wd_o   = REG_AW'(inst_i[20:16]);
            wreg_o = 1'b1;
        end
        if (op != OP_SPECIAL && aluop_o != EXE_NOP_OP) begin
            invalid_o = 1'b0;
            wd_o      = REG_AW'(inst_i[20:16]);
            wreg_o    = 1'b1;
        end
    end
endmodule

// File: rtl/id_pipe.sv
// Registered MIPS decode stage: Regfile read, EX/MEM forwarding, load-use
// stall, valid/ready ID/EX output register and saturating stall counter.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_pipe_if.slave          bus,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i
);
    aluop_t            dec_aluop;
    alusel_t           dec_alusel;
    logic              dec_reg1_read, dec_reg2_read;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_wd;
    logic              dec_wreg, dec_invalid;

    logic [1:0]        rd_en, ex_hit, mem_hit, hz;
    logic [REG_AW-1:0] rd_addr [2];
    logic [DATA_W-1:0] rf_data [2];
    logic [DATA_W-1:0] opnd    [2];
    logic              stall, out_free, in_ready, accept;

    logic                   valid_q, valid_d, wreg_q, wreg_d, invalid_q, invalid_d;
    aluop_t                 aluop_q, aluop_d;
    alusel_t                alusel_q, alusel_d;
    logic [DATA_W-1:0]      reg1_q, reg1_d, reg2_q, reg2_d;
    logic [REG_AW-1:0]      wd_q, wd_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
        .inst_i      (bus.inst_i),
        .aluop_o     (dec_aluop),
        .alusel_o    (dec_alusel),
        .reg1_read_o (dec_reg1_read),
        .reg2_read_o (dec_reg2_read),
        .reg1_addr_o (rd_addr[0]),
        .reg2_addr_o (rd_addr[1]),
        .imm_o       (dec_imm),
        .wd_o        (dec_wd),
        .wreg_o      (dec_wreg),
        .invalid_o   (dec_invalid)
    );

    assign rd_en       = rst ? 2'b00 : {dec_reg2_read, dec_reg1_read};
    assign reg1_read_o = rd_en[0];
    assign reg2_read_o = rd_en[1];
    assign reg1_addr_o = rd_addr[0];
    assign reg2_addr_o = rd_addr[1];
    assign rf_data[0]  = reg1_data_i;
    assign rf_data[1]  = reg2_data_i;

    // Without forwarding every RAW match on EX or MEM must stall instead.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ex_hit[gi]  = ex_wreg_i  && (ex_wd_i  == rd_addr[gi]) && (rd_addr[gi] != '0);
            assign mem_hit[gi] = mem_wreg_i && (mem_wd_i == rd_addr[gi]) && (rd_addr[gi] != '0);
            assign hz[gi]      = rd_en[gi] && ((ex_hit[gi] && (ex_is_load_i || FWD_EN == 0)) ||
                                               (mem_hit[gi] && FWD_EN == 0));
            assign opnd[gi]    = !rd_en[gi]                                   ? dec_imm     :
                                 (rd_addr[gi] == '0)                          ? '0          :
                                 (FWD_EN != 0 && ex_hit[gi] && !ex_is_load_i) ? ex_wdata_i  :
                                 (FWD_EN != 0 && mem_hit[gi])                 ? mem_wdata_i :
                                                                                rf_data[gi];
        end
    endgenerate

    assign stall        = bus.in_valid && (|hz);
    assign out_free     = !valid_q || bus.out_ready;
    assign in_ready     = flush_i || (!stall && out_free);
    assign accept       = bus.in_valid && in_ready && !flush_i;
    assign bus.in_ready = in_ready;

    always_comb begin
        valid_d     = valid_q;
        aluop_d     = aluop_q;
        alusel_d    = alusel_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        pc_d        = pc_q;
        invalid_d   = invalid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            aluop_d   = dec_aluop;
            alusel_d  = dec_alusel;
            reg1_d    = opnd[0];
            reg2_d    = opnd[1];
            wd_d      = dec_wd;
            wreg_d    = dec_wreg;
            pc_d      = bus.pc_i;
            invalid_d = dec_invalid;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
        if (stall && !flush_i && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q     <= 1'b0;
            aluop_q     <= EXE_NOP_OP;
            alusel_q    <= EXE_RES_NOP;
            reg1_q      <= DATA_W'(ZERO_WORD);
            reg2_q      <= DATA_W'(ZERO_WORD);
            wd_q        <= REG_AW'(NOP_REG_ADDR);
            wreg_q      <= 1'b0;
            pc_q        <= ZERO_WORD;
            invalid_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_d;
            invalid_q   <= invalid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.aluop_o        = aluop_q;
    assign bus.alusel_o       = alusel_q;
    assign bus.reg1_o         = reg1_q;
    assign bus.reg2_o         = reg2_q;
    assign bus.wd_o           = wd_q;
    assign bus.wreg_o         = wreg_q;
    assign bus.pc_o           = pc_q;
    assign bus.inst_invalid_o = invalid_q;
    assign bus.stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_id_pipe.sv
// Directed-vector bench for id_pipe: decode, forwarding, load-use stall,
// backpressure, flush, counter saturation, invalid opcode and async reset.
module tb_id_pipe;
    import id_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg1_read, reg2_read;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic        ex_wreg, ex_is_load, mem_wreg, flush;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    id_pipe_if #(.DATA_W(32), .REG_AW(5), .STALL_CNT_W(3)) bus ();

    id_pipe #(.DATA_W(32), .REG_AW(5), .FWD_EN(1), .STALL_CNT_W(3)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .reg1_read_o  (reg1_read),
        .reg2_read_o  (reg2_read),
        .reg1_addr_o  (reg1_addr),
        .reg2_addr_o  (reg2_addr),
        .reg1_data_i  (reg1_data),
        .reg2_data_i  (reg2_data),
        .ex_wreg_i    (ex_wreg),
        .ex_wd_i      (ex_wd),
        .ex_wdata_i   (ex_wdata),
        .ex_is_load_i (ex_is_load),
        .mem_wreg_i   (mem_wreg),
        .mem_wd_i     (mem_wd),
        .mem_wdata_i  (mem_wdata),
        .flush_i      (flush)
    );

    // Regfile model: register n holds 0xF000_000n
    assign reg1_data = 32'hF000_0000 | {27'd0, reg1_addr};
    assign reg2_data = 32'hF000_0000 | {27'd0, reg2_addr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-16s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %-16s val=%08h", tag, got);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = v;
        bus.pc_i     = pc;
        bus.inst_i   = inst;
    endtask

    task automatic set_fwd(input logic exw, input logic [4:0] exd, input logic [31:0] exdat, input logic exld,
                           input logic mw, input logic [4:0] md, input logic [31:0] mdat);
        ex_wreg = exw; ex_wd = exd; ex_wdata = exdat; ex_is_load = exld;
        mem_wreg = mw; mem_wd = md; mem_wdata = mdat;
    endtask

    task automatic check_out(input string tag, input logic [7:0] aluop, input logic [2:0] alusel,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                             input logic [31:0] pc);
        check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, ".aluop"}, {24'd0, bus.aluop_o}, {24'd0, aluop});
        check_eq({tag, ".alusel"}, {29'd0, bus.alusel_o}, {29'd0, alusel});
        check_eq({tag, ".reg1"}, bus.reg1_o, r1);
        check_eq({tag, ".reg2"}, bus.reg2_o, r2);
        check_eq({tag, ".wd"}, {27'd0, bus.wd_o}, {27'd0, wd});
        check_eq({tag, ".wreg"}, {31'd0, bus.wreg_o}, 32'd1);
        check_eq({tag, ".pc"}, bus.pc_o, pc);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
        check_eq({tag, ".aluop"}, {24'd0, bus.aluop_o}, 32'd0);
        check_eq({tag, ".alusel"}, {29'd0, bus.alusel_o}, 32'd0);
        check_eq({tag, ".reg1"}, bus.reg1_o, 32'd0);
        check_eq({tag, ".reg2"}, bus.reg2_o, 32'd0);
        check_eq({tag, ".pc"}, bus.pc_o, 32'd0);
        check_eq({tag, ".wd"}, {27'd0, bus.wd_o}, 32'd0);
        check_eq({tag, ".wreg"}, {31'd0, bus.wreg_o}, 32'd0);
        check_eq({tag, ".invalid"}, {31'd0, bus.inst_invalid_o}, 32'd0);
        check_eq({tag, ".stall_cnt"}, {29'd0, bus.stall_cnt_o}, 32'd0);
        check_eq({tag, ".rd1_en"}, {31'd0, reg1_read}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b0, 32'h0, 32'h3401_1100);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check_reset("rst");

        // ori $1,$0,0x1100
        rst = 1'b0;
        set_in(1'b1, 32'h100, 32'h3401_1100);
        #1;
        check_eq("ori.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("ori.rd1_en", {31'd0, reg1_read}, 32'd1);
        check_eq("ori.rd2_en", {31'd0, reg2_read}, 32'd0);
        @(negedge clk);
        check_out("ori", 8'h25, 3'd1, 32'h0, 32'h0000_1100, 5'd1, 32'h100);

        // or $3,$1,$2 with EX r1 and MEM r2 forwarding
        set_in(1'b1, 32'h104, 32'h0022_1825);
        set_fwd(1'b1, 5'd1, 32'hAAAA_0000, 1'b0, 1'b1, 5'd2, 32'h0000_5555);
        @(negedge clk);
        check_out("or_fwd", 8'h25, 3'd1, 32'hAAAA_0000, 32'h0000_5555, 5'd3, 32'h104);

        // addiu $6,$7,-4 from Regfile
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_in(1'b1, 32'h108, 32'h24E6_FFFC);
        @(negedge clk);
        check_out("addiu", 8'h56, 3'd4, 32'hF000_0007, 32'hFFFF_FFFC, 5'd6, 32'h108);

        // sra $8,$9,5
        set_in(1'b1, 32'h10C, 32'h0009_4143);
        @(negedge clk);
        check_out("sra", 8'h03, 3'd2, 32'h0000_0005, 32'hF000_0009, 5'd8, 32'h10C);

        // lui $10,0x8001
        set_in(1'b1, 32'h110, 32'h3C0A_8001);
        @(negedge clk);
        check_out("lui", 8'h25, 3'd1, 32'h8001_0000, 32'h8001_0000, 5'd10, 32'h110);

        // lw $4,-8($1)
        set_in(1'b1, 32'h114, 32'h8C24_FFF8);
        @(negedge clk);
        check_out("lw", 8'hE3, 3'd7, 32'hF000_0001, 32'hFFFF_FFF8, 5'd4, 32'h114);

        // andi $4,$0,0x8000 (zero-extended)
        set_in(1'b1, 32'h118, 32'h3004_8000);
        @(negedge clk);
        check_out("andi", 8'h24, 3'd1, 32'h0, 32'h0000_8000, 5'd4, 32'h118);

        // load-use: EX is lw r4, decode addu $5,$4,$4
        set_fwd(1'b1, 5'd4, 32'hDEAD_0000, 1'b1, 1'b0, 5'd0, 32'h0);
        set_in(1'b1, 32'h11C, 32'h0084_2821);
        #1;
        check_eq("lu.in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check_eq("lu.bubble", {31'd0, bus.out_valid}, 32'd0);
        check_eq("lu.stall_cnt", {29'd0, bus.stall_cnt_o}, 32'd1);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd4, 32'h1234_5678);
        #1;
        check_eq("lu.in_ready2", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        check_out("lu.addu", 8'h21, 3'd4, 32'h1234_5678, 32'h1234_5678, 5'd5, 32'h11C);
        check_eq("lu.stall_cnt2", {29'd0, bus.stall_cnt_o}, 32'd1);

        // backpressure: hold ori $2 for three cycles
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_in(1'b1, 32'h200, 32'h3402_00FF);
        @(negedge clk);
        check_out("bp.ori", 8'h25, 3'd1, 32'h0, 32'h0000_00FF, 5'd2, 32'h200);
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h204, 32'h3803_0F0F);
        #1;
        check_eq("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("bp.hold", 8'h25, 3'd1, 32'h0, 32'h0000_00FF, 5'd2, 32'h200);
            check_eq("bp.in_ready_h", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp.release", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        check_out("bp.xori", 8'h26, 3'd1, 32'h0, 32'h0000_0F0F, 5'd3, 32'h204);

        // flush with backpressure and a valid input: both dropped
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'h208, 32'h3004_1234);
        flush = 1'b1;
        #1;
        check_eq("fl.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        set_in(1'b0, 32'h20C, 32'h0);
        check_eq("fl.valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("fl.valid2", {31'd0, bus.out_valid}, 32'd0);

        // flush and load-use stall together: flush wins, counter holds
        set_fwd(1'b1, 5'd4, 32'hDEAD_0000, 1'b1, 1'b0, 5'd0, 32'h0);
        set_in(1'b1, 32'h210, 32'h0084_2821);
        flush = 1'b1;
        #1;
        check_eq("fs.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        check_eq("fs.stall_cnt", {29'd0, bus.stall_cnt_o}, 32'd1);
        check_eq("fs.valid", {31'd0, bus.out_valid}, 32'd0);

        // long stall: 3-bit counter saturates at 7
        repeat (8) @(negedge clk);
        check_eq("sat.stall_cnt", {29'd0, bus.stall_cnt_o}, 32'd7);
        check_eq("sat.valid", {31'd0, bus.out_valid}, 32'd0);

        // unknown opcode 0x3F
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_in(1'b1, 32'h300, 32'hFC00_0000);
        @(negedge clk);
        check_eq("inv.valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("inv.invalid", {31'd0, bus.inst_invalid_o}, 32'd1);
        check_eq("inv.wreg", {31'd0, bus.wreg_o}, 32'd0);
        check_eq("inv.aluop", {24'd0, bus.aluop_o}, 32'd0);

        // reset during backpressure discards the held instruction
        set_in(1'b1, 32'h304, 32'h3401_1100);
        @(negedge clk);
        check_out("rbp.ori", 8'h25, 3'd1, 32'h0, 32'h0000_1100, 5'd1, 32'h304);
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h308, 32'h3401_1100);
        @(negedge clk);
        check_eq("rbp.hold", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset("rbp.rst");
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("rbp.after", {31'd0, bus.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
